// File: rtl/vdb_led_pkg.sv
`default_nettype none
// vdb_led_pkg: shared mode encoding and per-LED state record for vdb_led_ctrl.
// Rev 1.0
package vdb_led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_t;

  localparam int VAL_W = 8;

  // bcnt is sized for the widest blink counter; narrower configs mask it.
  typedef struct packed {
    led_mode_t          mode;
    logic [VAL_W-1:0]   val;
    logic [VAL_W-1:0]   bcnt;
    logic               phase;
  } led_state_t;

  localparam led_state_t LED_STATE_RST = '{mode: LED_OFF, val: '0, bcnt: '0, phase: 1'b0};

  function automatic logic [VAL_W-1:0] blink_mask(input int bits);
    return VAL_W'((1 << bits) - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vdb_led_prescaler.sv
`default_nettype none
// vdb_led_prescaler: free-running divider, one-cycle tick every PRESCALE clocks.
// Rev 1.0
module vdb_led_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick_o = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/vdb_led_ctrl.sv
`default_nettype none
// vdb_led_ctrl: register-programmable OFF/ON/BLINK/PWM driver for a bank of LEDs.
// Rev 1.0
module vdb_led_ctrl
  import vdb_led_pkg::*;
#(
  parameter int LEDS       = 8,
  parameter int PRESCALE   = 1000,
  parameter int PWM_BITS   = 4,
  parameter int BLINK_BITS = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   cfg_valid_i,
  output logic                                   cfg_ready_o,
  input  logic [$clog2(LEDS > 1 ? LEDS : 2)-1:0] cfg_idx_i,
  input  logic [1:0]                             cfg_mode_i,
  input  logic [7:0]                             cfg_val_i,
  output logic                                   tick_o,
  output logic [LEDS-1:0]                        led_o
);

  localparam int IDX_W = $clog2(LEDS > 1 ? LEDS : 2);
  localparam logic [VAL_W-1:0] BMASK = blink_mask(BLINK_BITS);

  logic                tick;
  logic                cfg_ready;
  logic                accept;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [LEDS-1:0]     led_nxt;

  vdb_led_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick)
  );

  assign tick_o      = tick;
  assign cfg_ready_o = cfg_ready;
  assign accept      = cfg_valid_i & cfg_ready;

  // Shared PWM phase; config writes never disturb it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_ready <= 1'b0;
      pwm_cnt   <= '0;
    end else begin
      cfg_ready <= 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  generate
    for (genvar i = 0; i < LEDS; i++) begin : g_led
      led_state_t st;
      logic       hit;
      logic       out_nxt;

      // Out-of-range indices match no LED, so such writes are silently dropped.
      assign hit = accept && (cfg_idx_i == IDX_W'(i));

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          st <= LED_STATE_RST;
        end else if (hit) begin
          st.mode  <= led_mode_t'(cfg_mode_i);
          st.val   <= cfg_val_i;
          st.bcnt  <= '0;
          st.phase <= 1'b1;
        end else if (tick && (st.mode == LED_BLINK)) begin
          if (st.bcnt == (st.val & BMASK)) begin
            st.bcnt  <= '0;
            st.phase <= ~st.phase;
          end else begin
            st.bcnt <= (st.bcnt + 1'b1) & BMASK;
          end
        end
      end

      always_comb begin
        out_nxt = 1'b0;
        unique case (st.mode)
          LED_OFF:   out_nxt = 1'b0;
          LED_ON:    out_nxt = 1'b1;
          LED_BLINK: out_nxt = st.phase;
          LED_PWM:   out_nxt = (pwm_cnt < st.val[PWM_BITS-1:0]);
          default:   out_nxt = 1'b0;
        endcase
      end

      assign led_nxt[i] = out_nxt;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      led_o <= '0;
    end else begin
      led_o <= led_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vdb_led_ctrl.sv
`default_nettype none
// tb_vdb_led_ctrl: directed self-checking bench for vdb_led_ctrl (LEDS=6, PRESCALE=4).
// Rev 1.0
module tb_vdb_led_ctrl;
  import vdb_led_pkg::*;

  localparam int LEDS       = 6;
  localparam int PRESCALE   = 4;
  localparam int PWM_BITS   = 4;
  localparam int BLINK_BITS = 8;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [2:0]      cfg_idx   = '0;
  logic [1:0]      cfg_mode  = '0;
  logic [7:0]      cfg_val   = '0;
  logic            tick;
  logic [LEDS-1:0] led;

  int checks   = 0;
  int failures = 0;
  int pc       = 0;
  int cnt;

  vdb_led_ctrl #(
    .LEDS       (LEDS),
    .PRESCALE   (PRESCALE),
    .PWM_BITS   (PWM_BITS),
    .BLINK_BITS (BLINK_BITS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_idx_i   (cfg_idx),
    .cfg_mode_i  (cfg_mode),
    .cfg_val_i   (cfg_val),
    .tick_o      (tick),
    .led_o       (led)
  );

  always #5 clk = ~clk;

  // Expected prescaler count; a tick edge follows any negedge where pc==PRESCALE-1.
  always @(posedge clk) begin
    if (!rst_n) pc <= 0;
    else        pc <= (pc == PRESCALE - 1) ? 0 : pc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] idx, input led_mode_t mode, input logic [7:0] val);
    cfg_valid = 1'b1;
    cfg_idx   = idx;
    cfg_mode  = mode;
    cfg_val   = val;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick_slot();
    int n = 0;
    @(negedge clk);
    while (pc != PRESCALE - 1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (pc != PRESCALE - 1) begin
      failures++;
      $display("FAIL tick_slot observed=timeout expected=slot");
    end
  endtask

  initial begin
    // Reset held for three edges
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_led", led, 0);
      check("rst_ready", cfg_ready, 0);
      check("rst_tick", tick, 0);
    end
    rst_n = 1'b1;
    #1 check("ready_before_edge", cfg_ready, 0);
    @(negedge clk);
    check("ready_after_release", cfg_ready, 1);
    repeat (100) begin
      @(negedge clk);
      check("idle_led", led, 0);
      check("idle_tick", tick, (pc == PRESCALE - 1));
    end

    // ON/OFF two-edge latency
    cfg_write(3'd3, LED_ON, 8'd0);
    @(negedge clk); check("on_after_e0", led, 6'b000000);
    @(negedge clk); check("on_after_e1", led, 6'b001000);
    cfg_write(3'd3, LED_OFF, 8'd0);
    @(negedge clk); check("off_after_e0", led, 6'b001000);
    @(negedge clk); check("off_after_e1", led, 6'b000000);

    // Blink half-period of 3 ticks = 12 clocks, write lands on a tick edge
    wait_tick_slot();
    cfg_write(3'd0, LED_BLINK, 8'd2);
    @(negedge clk); check("blink_after_e0", led, 6'b000000);
    for (int j = 1; j <= 48; j++) begin
      @(negedge clk);
      check("blink_led0", led[0], 1 ^ (((j - 1) / 12) & 1));
      check("blink_others", led[5:1], 0);
    end
    cfg_write(3'd0, LED_OFF, 8'd0);

    // PWM duty over one full 64-clock period
    cfg_write(3'd1, LED_PWM, 8'd4);
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (64) begin @(negedge clk); cnt += int'(led[1]); end
    check("pwm_duty4", cnt, 16);
    cfg_write(3'd1, LED_PWM, 8'd0);
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (64) begin @(negedge clk); cnt += int'(led[1]); end
    check("pwm_duty0", cnt, 0);
    cfg_write(3'd1, LED_PWM, 8'd15);
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (64) begin @(negedge clk); cnt += int'(led[1]); end
    check("pwm_duty15", cnt, 60);
    cfg_write(3'd1, LED_OFF, 8'd0);

    // LED5 toggles every tick; LED2 written on a tick edge 8 clocks later
    wait_tick_slot();
    cfg_write(3'd5, LED_BLINK, 8'd0);
    @(negedge clk);
    repeat (7) @(negedge clk);
    cfg_write(3'd2, LED_BLINK, 8'd2);
    @(negedge clk);
    check("race_led5_e8", led[5], 0);
    check("race_led2_e8", led[2], 0);
    for (int m = 9; m <= 30; m++) begin
      @(negedge clk);
      check("race_led5", led[5], 1 ^ (((m - 1) / 4) & 1));
      check("race_led2", led[2], 1 ^ (((m - 9) / 12) & 1));
    end

    // Reset while blinking wipes all state
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_led", led, 0);
    check("midrst_ready", cfg_ready, 0);
    check("midrst_tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", cfg_ready, 1);
    repeat (20) begin
      @(negedge clk);
      check("midrst_led_stays", led, 0);
    end

    // Back-to-back writes: last one wins
    cfg_write(3'd4, LED_OFF, 8'd0);
    cfg_write(3'd4, LED_ON, 8'd0);
    cfg_write(3'd3, LED_ON, 8'd0);
    cfg_write(3'd3, LED_OFF, 8'd0);
    repeat (3) @(negedge clk);
    check("b2b_led", led, 6'b010000);

    // Out-of-range index is accepted and dropped
    check("oor_ready", cfg_ready, 1);
    cfg_write(3'd7, LED_OFF, 8'd0);
    check("oor_ready_after", cfg_ready, 1);
    cfg_write(3'd6, LED_ON, 8'd0);
    repeat (5) begin
      @(negedge clk);
      check("oor_led", led, 6'b010000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
